// File: rtl/cr_ob_frame_tracker_if.sv
// AXI-stream beat bundle used on both sides of the outbound frame tracker.
// The master drives the beat and tvalid; the slave drives tready.
interface cr_ob_frame_tracker_if #(
  parameter int DWIDTH  = 64,
  parameter int SWIDTH  = 8,
  parameter int UWIDTH  = 8,
  parameter int IDWIDTH = 1
);
  logic               tvalid;
  logic               tready;
  logic [DWIDTH-1:0]  tdata;
  logic [SWIDTH-1:0]  tstrb;
  logic [UWIDTH-1:0]  tuser;
  logic [IDWIDTH-1:0] tid;
  logic               tlast;

  modport master (output tvalid, tdata, tstrb, tuser, tid, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tuser, tid, tlast, output tready);
endinterface

// File: rtl/cr_ob_frame_tracker.sv
// Outbound frame tracker: forwards engine beats through a 2-entry skid
// buffer, checks descriptor framing on tuser and tlast placement, and keeps
// debug counters plus sticky error status.
//
// Handshake: a beat moves on a rising edge where tvalid && tready are both
// high. ob.tready is a register (1 when the buffer holds fewer than 2 beats
// after the current update); out.tvalid is high whenever the buffer is not
// empty, and the presented beat holds stable until it is taken.
module cr_ob_frame_tracker #(
  parameter int          DWIDTH     = 64,
  parameter int          SWIDTH     = 8,
  parameter int          UWIDTH     = 8,
  parameter int          IDWIDTH    = 1,
  parameter logic [7:0]  CQE_TYPE   = 8'h09,
  parameter logic [7:0]  STATS_TYPE = 8'h08
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cr_ob_frame_tracker_if.slave    ob,
  cr_ob_frame_tracker_if.master   out,
  input  logic                    clr_stats,
  output logic [31:0]             frame_cnt,
  output logic [31:0]             beat_cnt,
  output logic [15:0]             stats_desc_cnt,
  output logic [3:0]              err_status,
  output logic [15:0]             err_cnt,
  output logic                    dbg_fsm_state
);

  typedef struct packed {
    logic [DWIDTH-1:0]  data;
    logic [SWIDTH-1:0]  strb;
    logic [UWIDTH-1:0]  user;
    logic [IDWIDTH-1:0] id;
    logic               last;
  } beat_t;

  typedef enum logic {S_IDLE = 1'b0, S_IN_DESC = 1'b1} state_t;

  beat_t       mem_q [2];
  beat_t       in_beat, head;
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        ob_tready_q, ob_tready_d;
  logic        accept, deliver;

  state_t      state_q, state_d;
  logic        is_cqe_q, is_cqe_d, is_stats_q, is_stats_d;
  logic        is_start, is_end, cqe_end, stats_inc;
  logic [3:0]  err_evt;

  logic [31:0] frame_cnt_q, frame_cnt_d, beat_cnt_q, beat_cnt_d;
  logic [15:0] stats_cnt_q, stats_cnt_d, err_cnt_q, err_cnt_d;
  logic [3:0]  err_status_q, err_status_d;
  logic [31:0] frame_base, beat_base;
  logic [15:0] stats_base, err_cnt_base;
  logic [3:0]  err_status_base;

  assign accept  = ob.tvalid && ob_tready_q;
  assign deliver = out.tvalid && out.tready;
  assign in_beat = '{data: ob.tdata, strb: ob.tstrb, user: ob.tuser, id: ob.tid, last: ob.tlast};
  assign head    = mem_q[rd_ptr_q];

  assign ob.tready  = ob_tready_q;
  assign out.tvalid = (count_q != 2'd0);
  assign out.tdata  = head.data;
  assign out.tstrb  = head.strb;
  assign out.tuser  = head.user;
  assign out.tid    = head.id;
  assign out.tlast  = head.last;

  // Buffer occupancy and the registered ready that follows it.
  always_comb begin
    count_d = count_q;
    case ({accept, deliver})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    ob_tready_d = (count_d != 2'd2);
  end

  // Skid buffer storage and pointers; reset drops any held beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      ob_tready_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= in_beat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (deliver) rd_ptr_q <= ~rd_ptr_q;
      count_q     <= count_d;
      ob_tready_q <= ob_tready_d;
    end
  end

  // Framing checker: next state, descriptor type latch and error events.
  always_comb begin
    state_d    = state_q;
    is_cqe_d   = is_cqe_q;
    is_stats_d = is_stats_q;
    err_evt    = 4'b0000;
    cqe_end    = 1'b0;
    stats_inc  = 1'b0;
    is_start   = (ob.tuser == UWIDTH'(1));
    is_end     = (ob.tuser == UWIDTH'(2));
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (is_start) begin
            state_d    = S_IN_DESC;
            is_cqe_d   = (ob.tdata[7:0] == CQE_TYPE);
            is_stats_d = (ob.tdata[7:0] == STATS_TYPE);
          end else begin
            err_evt[0] = 1'b1;
          end
        end
        default: begin
          if (is_start) begin
            // Restart: the new start beat opens a fresh descriptor.
            err_evt[1] = 1'b1;
            is_cqe_d   = (ob.tdata[7:0] == CQE_TYPE);
            is_stats_d = (ob.tdata[7:0] == STATS_TYPE);
          end else if (is_end) begin
            state_d   = S_IDLE;
            stats_inc = is_stats_q;
            cqe_end   = is_cqe_q;
          end
        end
      endcase
      if (ob.tlast && !cqe_end) err_evt[2] = 1'b1;
      if (cqe_end && !ob.tlast) err_evt[3] = 1'b1;
    end
  end

  // Counters: a clear zeroes the base, then this cycle's beat is added on top.
  always_comb begin
    frame_base      = clr_stats ? 32'd0 : frame_cnt_q;
    beat_base       = clr_stats ? 32'd0 : beat_cnt_q;
    stats_base      = clr_stats ? 16'd0 : stats_cnt_q;
    err_cnt_base    = clr_stats ? 16'd0 : err_cnt_q;
    err_status_base = clr_stats ? 4'd0  : err_status_q;
    frame_cnt_d     = frame_base + 32'(accept && ob.tlast);
    beat_cnt_d      = beat_base + 32'(accept);
    stats_cnt_d     = stats_base + 16'(stats_inc);
    err_status_d    = err_status_base | err_evt;
    err_cnt_d       = err_cnt_base;
    if ((|err_evt) && (err_cnt_base != 16'hFFFF)) err_cnt_d = err_cnt_base + 16'd1;
  end

  // Checker state and statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      is_cqe_q     <= 1'b0;
      is_stats_q   <= 1'b0;
      frame_cnt_q  <= 32'd0;
      beat_cnt_q   <= 32'd0;
      stats_cnt_q  <= 16'd0;
      err_cnt_q    <= 16'd0;
      err_status_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      is_cqe_q     <= is_cqe_d;
      is_stats_q   <= is_stats_d;
      frame_cnt_q  <= frame_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      stats_cnt_q  <= stats_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_status_q <= err_status_d;
    end
  end

  assign frame_cnt      = frame_cnt_q;
  assign beat_cnt       = beat_cnt_q;
  assign stats_desc_cnt = stats_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign err_status     = err_status_q;
  assign dbg_fsm_state  = (state_q == S_IN_DESC);

endmodule

// File: tb/tb_cr_ob_frame_tracker.sv
// Bench for the outbound frame tracker: vector table for framing/counter
// behaviour plus directed sequences for back-pressure, wrap, saturation,
// coincident clear and mid-descriptor reset.
module tb_cr_ob_frame_tracker;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int UW = 8;
  localparam int IW = 1;
  localparam int BW = DW + SW + UW + IW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_stats = 1'b0;
  always #5 clk = ~clk;

  cr_ob_frame_tracker_if #(.DWIDTH(DW), .SWIDTH(SW), .UWIDTH(UW), .IDWIDTH(IW)) ob_if ();
  cr_ob_frame_tracker_if #(.DWIDTH(DW), .SWIDTH(SW), .UWIDTH(UW), .IDWIDTH(IW)) out_if ();

  logic [31:0] frame_cnt, beat_cnt;
  logic [15:0] stats_desc_cnt, err_cnt;
  logic [3:0]  err_status;
  logic        dbg_fsm_state;

  cr_ob_frame_tracker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ob             (ob_if),
    .out            (out_if),
    .clr_stats      (clr_stats),
    .frame_cnt      (frame_cnt),
    .beat_cnt       (beat_cnt),
    .stats_desc_cnt (stats_desc_cnt),
    .err_status     (err_status),
    .err_cnt        (err_cnt),
    .dbg_fsm_state  (dbg_fsm_state)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt = 0;
  int fail_cnt = 0;
  int deliv_cnt = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] mon_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every delivered beat must match the oldest accepted beat.
  always @(negedge clk) begin
    if (rst_n && out_if.tvalid && out_if.tready) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        fail_cnt++;
        $display("FAIL deliver_unexpected: got %0h expected none", out_if.tdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("deliver", {out_if.tdata, out_if.tstrb, out_if.tuser, out_if.tid, out_if.tlast}, mon_e);
      end
      deliv_cnt++;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [UW-1:0] user, input logic [DW-1:0] data,
                           input logic last, input logic clr);
    int  cyc = 0;
    bit  acc = 0;
    bit  timeout = 0;
    logic [SW-1:0] strb;
    logic [IW-1:0] id;
    strb = data[15:8] ^ 8'h5A;
    id   = data[8];
    @(posedge clk); #1;
    ob_if.tvalid = 1'b1;
    ob_if.tdata  = data;
    ob_if.tstrb  = strb;
    ob_if.tuser  = user;
    ob_if.tid    = id;
    ob_if.tlast  = last;
    clr_stats    = clr;
    while (!acc && !timeout) begin
      @(negedge clk);
      if (ob_if.tready) acc = 1;
      else if (cyc >= 200) timeout = 1;
      cyc++;
      @(posedge clk); #1;
      clr_stats = 1'b0;
    end
    if (timeout) begin
      chk_cnt++;
      fail_cnt++;
      $display("FAIL send_timeout: got tready=0 expected 1 within 200 cycles");
    end else begin
      exp_q.push_back({data, strb, user, id, last});
    end
    ob_if.tvalid = 1'b0;
  endtask

  // Back-to-back tuser=0 beats; each one in IDLE is a framing error.
  task automatic stream_err(input int n);
    int acc = 0;
    int cyc = 0;
    @(posedge clk); #1;
    ob_if.tvalid = 1'b1;
    ob_if.tdata  = '0;
    ob_if.tstrb  = '0;
    ob_if.tuser  = '0;
    ob_if.tid    = '0;
    ob_if.tlast  = 1'b0;
    while (acc < n && cyc < n + 100) begin
      @(negedge clk);
      if (ob_if.tready) begin
        acc++;
        exp_q.push_back('0);
      end
      cyc++;
      @(posedge clk); #1;
    end
    ob_if.tvalid = 1'b0;
    if (acc < n) begin
      chk_cnt++;
      fail_cnt++;
      $display("FAIL stream_timeout: got %0d beats expected %0d", acc, n);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        clr;
    logic [7:0]  user;
    logic [7:0]  typ;
    logic        last;
    logic [3:0]  e_err;
    logic [15:0] e_errcnt;
    logic [31:0] e_frame;
    logic [31:0] e_beat;
    logic [15:0] e_stats;
    logic        e_state;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] hold_data;
    int deliv0;

    ob_if.tvalid = 1'b0; ob_if.tdata = '0; ob_if.tstrb = '0;
    ob_if.tuser = '0; ob_if.tid = '0; ob_if.tlast = 1'b0;
    out_if.tready = 1'b1;

    //            clr   user   typ    last  err    errcnt  frame  beat   stats  state
    vecs[0]  = '{1'b0, 8'd1, 8'h09, 1'b0, 4'h0, 16'd0, 32'd0, 32'd1, 16'd0, 1'b1};
    vecs[1]  = '{1'b0, 8'd0, 8'h00, 1'b0, 4'h0, 16'd0, 32'd0, 32'd2, 16'd0, 1'b1};
    vecs[2]  = '{1'b0, 8'd0, 8'h00, 1'b0, 4'h0, 16'd0, 32'd0, 32'd3, 16'd0, 1'b1};
    vecs[3]  = '{1'b0, 8'd2, 8'h00, 1'b1, 4'h0, 16'd0, 32'd1, 32'd4, 16'd0, 1'b0};
    vecs[4]  = '{1'b0, 8'd1, 8'h08, 1'b0, 4'h0, 16'd0, 32'd1, 32'd5, 16'd0, 1'b1};
    vecs[5]  = '{1'b0, 8'd2, 8'h00, 1'b0, 4'h0, 16'd0, 32'd1, 32'd6, 16'd1, 1'b0};
    vecs[6]  = '{1'b0, 8'd1, 8'h09, 1'b0, 4'h0, 16'd0, 32'd1, 32'd7, 16'd1, 1'b1};
    vecs[7]  = '{1'b0, 8'd2, 8'h00, 1'b0, 4'h8, 16'd1, 32'd1, 32'd8, 16'd1, 1'b0};
    vecs[8]  = '{1'b1, 8'd0, 8'h00, 1'b0, 4'h1, 16'd1, 32'd0, 32'd1, 16'd0, 1'b0};
    vecs[9]  = '{1'b0, 8'd1, 8'h09, 1'b0, 4'h1, 16'd1, 32'd0, 32'd2, 16'd0, 1'b1};
    vecs[10] = '{1'b0, 8'd1, 8'h08, 1'b0, 4'h3, 16'd2, 32'd0, 32'd3, 16'd0, 1'b1};
    vecs[11] = '{1'b0, 8'd0, 8'h00, 1'b1, 4'h7, 16'd3, 32'd1, 32'd4, 16'd0, 1'b1};
    vecs[12] = '{1'b0, 8'd2, 8'h00, 1'b0, 4'h7, 16'd3, 32'd1, 32'd5, 16'd1, 1'b0};
    vecs[13] = '{1'b0, 8'd5, 8'h00, 1'b0, 4'h7, 16'd4, 32'd1, 32'd6, 16'd1, 1'b0};
    vecs[14] = '{1'b0, 8'd2, 8'h00, 1'b1, 4'h7, 16'd5, 32'd2, 32'd7, 16'd1, 1'b0};
    vecs[15] = '{1'b1, 8'd1, 8'h09, 1'b0, 4'h0, 16'd0, 32'd0, 32'd1, 16'd0, 1'b1};
    vecs[16] = '{1'b0, 8'd2, 8'h00, 1'b1, 4'h0, 16'd0, 32'd1, 32'd2, 16'd0, 1'b0};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", ob_if.tready, 1'b0);
    check("rst_tvalid", out_if.tvalid, 1'b0);
    check("rst_tdata", out_if.tdata, '0);
    check("rst_counts", {frame_cnt, beat_cnt, stats_desc_cnt, err_cnt, err_status}, '0);
    check("rst_state", dbg_fsm_state, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("tready_after_rst", ob_if.tready, 1'b1);

    // Table: one beat per vector, with out_tready held high.
    for (int i = 0; i < 17; i++) begin
      send_beat(vecs[i].user, {32'hC0DE0000 + 32'(i), 24'hABCD00, vecs[i].typ},
                vecs[i].last, vecs[i].clr);
      @(negedge clk);
      check($sformatf("v%0d_latency", i), out_if.tvalid, 1'b1);
      check($sformatf("v%0d_err_status", i), err_status, vecs[i].e_err);
      check($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].e_errcnt);
      check($sformatf("v%0d_frame_cnt", i), frame_cnt, vecs[i].e_frame);
      check($sformatf("v%0d_beat_cnt", i), beat_cnt, vecs[i].e_beat);
      check($sformatf("v%0d_stats_cnt", i), stats_desc_cnt, vecs[i].e_stats);
      check($sformatf("v%0d_state", i), dbg_fsm_state, vecs[i].e_state);
    end

    // Back-pressure: two beats fill the buffer, third waits for the sink.
    @(posedge clk); #1;
    out_if.tready = 1'b0;
    deliv0 = deliv_cnt;
    hold_data = 64'h1111_2222_3333_4409;
    send_beat(8'd1, hold_data, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_tready_one", ob_if.tready, 1'b1);
    send_beat(8'd0, 64'h5555_6666_7777_8800, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_tready_full", ob_if.tready, 1'b0);
    check("bp_tvalid", out_if.tvalid, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("bp_hold_data", out_if.tdata, hold_data);
      check("bp_hold_user", out_if.tuser, 8'd1);
    end
    fork
      send_beat(8'd2, 64'h9999_AAAA_BBBB_CC00, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        out_if.tready = 1'b1;
        @(negedge clk);
        check("bp_tready_hold", ob_if.tready, 1'b0);
        @(negedge clk);
        check("bp_tready_rise", ob_if.tready, 1'b1);
      end
    join
    repeat (4) @(negedge clk);
    check("bp_delivered", deliv_cnt - deliv0, 3);
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_frame_cnt", frame_cnt, 32'd2);
    check("bp_beat_cnt", beat_cnt, 32'd5);
    check("bp_err_status", err_status, 4'h0);

    // beat_cnt wrap.
    @(posedge clk); #1;
    force dut.beat_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    check("wrap_preload", beat_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    release dut.beat_cnt_q;
    send_beat(8'd1, 64'h0000_0000_0000_0109, 1'b0, 1'b0);
    @(negedge clk);
    check("wrap_beat_cnt", beat_cnt, 32'd0);
    send_beat(8'd2, 64'h0000_0000_0000_0200, 1'b1, 1'b0);
    @(negedge clk);
    check("wrap_beat_cnt_next", beat_cnt, 32'd1);
    check("wrap_err_status", err_status, 4'h0);

    // err_cnt saturation.
    @(posedge clk); #1;
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    @(negedge clk);
    check("clr_counts", {frame_cnt, beat_cnt, stats_desc_cnt, err_cnt, err_status}, '0);
    stream_err(65535);
    @(negedge clk);
    check("sat_err_cnt_reach", err_cnt, 16'hFFFF);
    check("sat_err_status", err_status, 4'h1);
    stream_err(1);
    @(negedge clk);
    check("sat_err_cnt_hold", err_cnt, 16'hFFFF);
    check("sat_beat_cnt", beat_cnt, 32'd65536);
    repeat (4) @(negedge clk);
    check("sat_queue_empty", exp_q.size(), 0);

    // Clear coincident with an error beat: clear first, then this beat counts.
    send_beat(8'd0, 64'h0000_0000_0000_0000, 1'b0, 1'b1);
    @(negedge clk);
    check("clr_coinc_err_cnt", err_cnt, 16'd1);
    check("clr_coinc_err_status", err_status, 4'h1);
    check("clr_coinc_beat_cnt", beat_cnt, 32'd1);

    // Reset mid-descriptor with two beats buffered.
    @(posedge clk); #1;
    out_if.tready = 1'b0;
    send_beat(8'd1, 64'hDEAD_BEEF_0000_0009, 1'b0, 1'b0);
    send_beat(8'd0, 64'hDEAD_BEEF_0000_0100, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_state", dbg_fsm_state, 1'b1);
    check("mid_tvalid", out_if.tvalid, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_tvalid", out_if.tvalid, 1'b0);
    check("mid_rst_state", dbg_fsm_state, 1'b0);
    check("mid_rst_tready", ob_if.tready, 1'b0);
    check("mid_rst_tdata", out_if.tdata, '0);
    check("mid_rst_counts", {frame_cnt, beat_cnt, err_cnt, err_status}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_if.tready = 1'b1;
    send_beat(8'd1, 64'h0000_0000_0000_0008, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_err_status", err_status, 4'h0);
    check("post_rst_err_cnt", err_cnt, 16'd0);
    check("post_rst_state", dbg_fsm_state, 1'b1);
    check("post_rst_beat_cnt", beat_cnt, 32'd1);
    send_beat(8'd2, 64'h0000_0000_0000_0200, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_stats_cnt", stats_desc_cnt, 16'd1);
    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/cr_ob_frame_tracker.md
Name: cr_ob_frame_tracker

Overview:
- Sits directly downstream of the cr_cddip outbound AXI-stream port (ob_*). It consumes every beat the engine emits and forwards it unchanged through a 2-entry skid buffer to the host-side sink.
- Tracks descriptor framing on the tuser side-band: 1 = descriptor start, 2 = descriptor end, 0 = payload.
- Checks that tlast marks exactly the end of each CQE descriptor (start beat with tdata[7:0]=0x09).
- Exposes frame/beat counters and sticky protocol-error status for debug readout.

Parameters:
- DWIDTH, 64, tdata width
- SWIDTH, 8, tstrb width
- UWIDTH, 8, tuser width
- IDWIDTH, 1, tid width
- CQE_TYPE, 8'h09, tdata[7:0] value on a start beat that opens a CQE descriptor
- STATS_TYPE, 8'h08, tdata[7:0] value on a start beat that opens a stats descriptor

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- ob_tvalid  in  1  engine beat valid
- ob_tready  out  1  back-pressure to engine
- ob_tdata  in  DWIDTH  beat data
- ob_tstrb  in  SWIDTH  byte strobes
- ob_tuser  in  UWIDTH  framing code
- ob_tid  in  IDWIDTH  stream id
- ob_tlast  in  1  end of CQE descriptor
- out_tvalid  out  1  forwarded beat valid
- out_tready  in  1  sink ready
- out_tdata / out_tstrb / out_tuser / out_tid / out_tlast  out  same widths as inputs  forwarded beat
- clr_stats  in  1  single-cycle pulse; clears counters and sticky errors
- frame_cnt  out  32  tlast beats accepted; wraps
- beat_cnt  out  32  beats accepted; wraps
- stats_desc_cnt  out  16  stats descriptors closed; wraps
- err_status  out  4  sticky: [0] payload/end beat outside a descriptor, [1] start beat inside a descriptor, [2] tlast on a beat that is not a CQE end, [3] CQE end without tlast
- err_cnt  out  16  total error events; saturates at 16'hFFFF

Behaviour:
- A beat is accepted when ob_tvalid && ob_tready. A beat is delivered when out_tvalid && out_tready.
- Skid buffer has 2 entries:
  - ob_tready is registered and equals "occupancy < 2" after the update.
  - Minimum latency is 1 cycle, from acceptance to out_tvalid.
  - Output fields hold stable while out_tvalid && !out_tready.
  - Data, strobe, tuser, tid and tlast pass through bit-exact.
- Accept and deliver in the same cycle: occupancy is unchanged. At full occupancy with out_tready=1, ob_tready stays 0 that cycle and rises the next cycle.
- Reset: ob_tready=0 during reset and 1 on the first cycle after rst_n=1. out_tvalid=0, all out_* data=0, all counters=0, err_status=0, FSM=IDLE. Beats held in the buffer are discarded on reset.
- Checker FSM advances on accepted beats only (input side). State IDLE:
  - tuser=1 -> IN_DESC; latch is_cqe=(tdata[7:0]==CQE_TYPE) and is_stats=(tdata[7:0]==STATS_TYPE).
  - tuser=0 or 2 -> err[0]; stay IDLE.
- State IN_DESC:
  - tuser=0 -> stay.
  - tuser=2 -> IDLE. If is_stats, stats_desc_cnt++.
  - tuser=1 -> err[1]; restart the descriptor with the new type latched.
- Any other tuser value is treated as 0.
- tlast checks, on every accepted beat:
  - tlast=1 is legal only when the beat is tuser=2 in IN_DESC with is_cqe=1; otherwise err[2].
  - A CQE end beat with tlast=0 -> err[3].
  - frame_cnt increments on every accepted beat with tlast=1, legal or not.
- A single beat may raise several error bits. err_cnt increments by 1 per beat that raises any error.
- clr_stats clears all counters and err_status. If clr_stats coincides with an accepted beat, the clear applies first and that beat's increments and errors then apply (result is 1, not 0). clr_stats does not change FSM state or buffer contents.
- beat_cnt and frame_cnt wrap from 32'hFFFFFFFF to 0. err_cnt holds at 16'hFFFF.

Test Plan:
- Reset then CQE descriptor (tuser 1/tdata 0x09, 0, 0, 2+tlast) with out_tready=1 -> 4 beats forwarded bit-exact, each 1 cycle after acceptance; frame_cnt=1, beat_cnt=4, err_status=0.
- Hold out_tready=0 and stream 3 beats -> ob_tready drops after 2 accepted; release -> all 3 delivered in order, none lost or duplicated.
- Stats descriptor (tuser 1/0x08, 2, tlast=0) -> stats_desc_cnt=1, no error. Same CQE end with tlast=0 -> err_status=4'b1000, err_cnt=1.
- tuser=0 beat in IDLE, then tuser=1 twice without an end, then tlast on a payload beat -> err_status=4'b0111, err_cnt=3.
- Preload beat_cnt to 32'hFFFFFFFF, accept 1 beat -> beat_cnt=0. Force 65536 errors -> err_cnt=16'hFFFF.
- clr_stats coincident with an error beat -> err_cnt=1. rst_n=0 mid-descriptor with 2 beats buffered -> out_tvalid=0 next cycle, FSM IDLE, a new tuser=1 accepted without error.
